adder_pipe_param: RTL

- Parametrised, pipelined successor of the 16-bit hierarchical ripple adder: WIDTH-bit add/subtract split into SEG_W-bit segments, one segment per pipeline stage, with carry registered between stages.
- Valid/ready handshake on input and output; whole-pipe stall on output backpressure.
- Sits in datapath/ALU front-ends where a long combinational carry chain breaks timing.

---
 rtl/adder_pipe_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/adder_pipe_param.sv
// Pipelined WIDTH-bit add/subtract, one SEG_W-bit segment per stage with registered carries.
// Latency NSTG cycles; output stall freezes the whole pipe (in_ready = !out_valid || out_ready).
module adder_pipe_param #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf
);
    localparam int NSTG = WIDTH / SEG_W;

    logic             en;
    logic [WIDTH-1:0] bx;
    logic             c0;

    // Stage register banks; index k holds the state leaving stage k.
    logic [NSTG-1:0]  v_q;
    logic [NSTG-1:0]  c_q;
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];

    // Stage inputs and next-state values.
    logic [NSTG-1:0]  v_in;
    logic [NSTG-1:0]  c_in;
    logic [NSTG-1:0]  c_n;
    logic [WIDTH-1:0] a_in [NSTG];
    logic [WIDTH-1:0] b_in [NSTG];
    logic [WIDTH-1:0] s_in [NSTG];
    logic [WIDTH-1:0] s_n  [NSTG];
    logic [SEG_W:0]   seg;

    assign bx = sub ? ~b : b;
    assign c0 = sub ? ~cin : cin;

    assign out_valid = v_q[NSTG-1];
    assign y         = s_q[NSTG-1];
    assign co        = c_q[NSTG-1];
    assign ovf       = (a_q[NSTG-1][WIDTH-1] == b_q[NSTG-1][WIDTH-1]) &&
                       (s_q[NSTG-1][WIDTH-1] != a_q[NSTG-1][WIDTH-1]);

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        seg     = '0;
        v_in    = '0;
        c_in    = '0;
        c_n     = '0;
        a_in[0] = a;
        b_in[0] = bx;
        s_in[0] = '0;
        c_in[0] = c0;
        v_in[0] = in_valid;
        for (int k = 1; k < NSTG; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            seg = {1'b0, a_in[k][k*SEG_W +: SEG_W]} +
                  {1'b0, b_in[k][k*SEG_W +: SEG_W]} +
                  {{SEG_W{1'b0}}, c_in[k]};
            s_n[k] = s_in[k];
            s_n[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            c_n[k] = seg[SEG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            v_q <= v_in;
            c_q <= c_n;
            for (int k = 0; k < NSTG; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_n[k];
            end
        end
    end
endmodule
